// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for hazard_stall_ctrl: FSM states, RV32M funct3 codes,
// the x0 register index and the default M-unit latencies.
package hazard_stall_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [4:0] X0_IDX = 5'd0;

    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 32;
    localparam int DEF_CNT_W   = 6;

    // Divide and remainder share the long-latency path.
    function automatic logic is_div(input logic [2:0] funct3);
        case (funct3)
            F3_DIV, F3_DIVU, F3_REM, F3_REMU:      is_div = 1'b1;
            F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU:  is_div = 1'b0;
            default:                               is_div = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_muldiv_timer.sv
// Loadable down-counter that tracks how long an M op still occupies EX.
// Loaded with latency-1 on issue; expire flags the final busy cycle.
module hazard_stall_ctrl_muldiv_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] value_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (value_q != '0) begin
            value_q <= value_q - CNT_W'(1);
        end
    end

    assign value  = value_q;
    assign expire = (value_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage RV32IM pipeline: load-use stalls,
// EX redirect flushes and multi-cycle M-op sequencing.
// Optional build macro STALL_PERF_CNT_EN adds the stall_cycles counter port.
//
// Control semantics: all controls are level signals valid for the current
// cycle; a stall holds the named register across the next rising edge, a
// bubble/flush loads a NOP at that edge. muldiv_start is a one-cycle pulse
// that is high in the first cycle the M op sits in EX.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_is_muldiv,
    input  logic [2:0]       id_funct3,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             muldiv_start,
    output logic             muldiv_busy,
    output logic             dbg_state,
    output logic [CNT_W-1:0] dbg_count
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
    localparam logic             MUL_MULTI = (MUL_LAT > 1);
    localparam logic             DIV_MULTI = (DIV_LAT > 1);

    state_t           state_q;
    state_t           state_d;
    logic             start_q;
    logic             issue;
    logic             lu_hazard;
    logic             sel_div;
    logic             lat_multi;
    logic [CNT_W-1:0] lat_load;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_expire;

    assign lu_hazard = ex_mem_read && (ex_rd != X0_IDX) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign sel_div   = is_div(id_funct3);
    assign lat_load  = sel_div ? DIV_LOAD  : MUL_LOAD;
    assign lat_multi = sel_div ? DIV_MULTI : MUL_MULTI;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= issue;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        muldiv_busy  = 1'b0;
        issue        = 1'b0;
        tmr_load     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (lu_hazard) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (id_is_muldiv) begin
                    issue = 1'b1;
                    // Single-cycle ops flow through without leaving RUN.
                    if (lat_multi) begin
                        state_d  = ST_MD_BUSY;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_MD_BUSY: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                ex_hold     = 1'b1;
                muldiv_busy = 1'b1;
                if (tmr_expire) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Controls stay quiet while reset is held, whatever the inputs do.
        if (!reset_n) begin
            state_d      = ST_RUN;
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            ex_hold      = 1'b0;
            muldiv_busy  = 1'b0;
            issue        = 1'b0;
            tmr_load     = 1'b0;
        end
    end

    hazard_stall_ctrl_muldiv_timer #(
        .CNT_W (CNT_W)
    ) u_muldiv_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (lat_load),
        .value    (tmr_value),
        .expire   (tmr_expire)
    );

    assign muldiv_start = start_q;
    assign dbg_state    = (state_q == ST_MD_BUSY);
    assign dbg_count    = tmr_value;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (pc_stall) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    // No stall-cycle counter in this configuration.
`endif

endmodule
